bram_uploader: RTL and testbench

BRAM_UPLOADER -- requirements
Module: bram_uploader

---
 rtl/uploader_pkg.sv | 24 ++
 rtl/tx_byte_issuer.sv | 67 ++++++
 rtl/bram_uploader.sv | 224 ++++++++++++++++++++++
 tb/tb_bram_uploader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uploader_pkg.sv
// ----------------------------------------------------------------------------
// uploader_pkg
//   Types and constants shared by the BRAM uploader and its byte issuer.
//   - state_e             : upload FSM state encoding
//   - DEFAULT_HEADER_BYTE : frame start marker used when the top is not
//                           overridden
// ----------------------------------------------------------------------------
package uploader_pkg;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR     = 4'd1,
    LEN_HI  = 4'd2,
    LEN_LO  = 4'd3,
    RD_REQ  = 4'd4,
    RD_WAIT = 4'd5,
    DATA    = 4'd6,
    SUM     = 4'd7,
    FIN     = 4'd8
  } state_e;

endpackage

// File: rtl/tx_byte_issuer.sv
// ----------------------------------------------------------------------------
// tx_byte_issuer
//   Owns the handshake with the UART transmitter. A send request registers the
//   byte onto tx_byte (held until the next request), raises tx_trigger for
//   exactly one cycle and marks a byte as outstanding. The transmitter's
//   tx_done only counts while a byte is outstanding; that qualified pulse is
//   returned to the FSM as byte_sent. Stray tx_done pulses are dropped here.
//
//   Ports
//     clk, rst    : clock, synchronous active-high reset
//     send_req    : FSM wants a byte sent (combinational, one cycle)
//     send_byte   : byte to send, valid with send_req
//     tx_done     : transmitter finished a byte (one-cycle pulse)
//     tx_byte     : byte presented to the transmitter
//     tx_trigger  : one-cycle start pulse to the transmitter
//     byte_sent   : qualified completion strobe back to the FSM
// ----------------------------------------------------------------------------
module tx_byte_issuer (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [7:0] send_byte,
  input  logic       tx_done,
  output logic [7:0] tx_byte,
  output logic       tx_trigger,
  output logic       byte_sent
);

  logic [7:0] tx_byte_q,     tx_byte_d;
  logic       tx_trigger_q,  tx_trigger_d;
  logic       outstanding_q, outstanding_d;

  // A completion is only meaningful while a byte is in flight.
  assign byte_sent = tx_done & outstanding_q;

  always_comb begin
    tx_byte_d     = tx_byte_q;
    tx_trigger_d  = 1'b0;
    outstanding_d = outstanding_q;
    if (byte_sent) begin
      outstanding_d = 1'b0;
    end
    // The FSM issues the next byte in the same cycle it sees byte_sent, so a
    // new request must win over the clear above.
    if (send_req) begin
      tx_byte_d     = send_byte;
      tx_trigger_d  = 1'b1;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte_q     <= 8'h00;
      tx_trigger_q  <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      tx_byte_q     <= tx_byte_d;
      tx_trigger_q  <= tx_trigger_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_trigger = tx_trigger_q;

endmodule

// File: rtl/bram_uploader.sv
// ----------------------------------------------------------------------------
// bram_uploader
//   Streams an inclusive BRAM address range out through a byte-wide UART
//   transmitter as a framed packet:
//     HEADER_BYTE, LEN_HI, LEN_LO, data[start..end], CHECKSUM
//   LEN is end_address - start_address (byte count minus one) and CHECKSUM is
//   the modulo-256 sum of the data bytes only.
//
//   Parameters
//     HEADER_BYTE       : frame start marker
//     BRAM_READ_LATENCY : cycles from bram_address to valid bram_byte_read (>=1)
//
//   Ports
//     clk, rst                   : clock, synchronous active-high reset
//     start                      : one-cycle upload request
//     start_address, end_address : inclusive range, sampled on accepted start
//     bram_byte_read             : BRAM read data
//     bram_address, bram_mode    : BRAM read address, mode (always read = 0)
//     tx_byte, tx_trigger        : byte and one-cycle send pulse to the UART
//     tx_done                    : one-cycle completion pulse from the UART
//     busy                       : upload in progress
//     done                       : one-cycle completion pulse
//     error                      : one-cycle pulse for start_address > end_address
// ----------------------------------------------------------------------------
module bram_uploader
  import uploader_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE       = DEFAULT_HEADER_BYTE,
  parameter int         BRAM_READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_address,
  input  logic [15:0] end_address,
  input  logic [7:0]  bram_byte_read,
  output logic [15:0] bram_address,
  output logic        bram_mode,
  output logic [7:0]  tx_byte,
  output logic        tx_trigger,
  input  logic        tx_done,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int WAIT_W = (BRAM_READ_LATENCY > 1) ? $clog2(BRAM_READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BRAM_READ_LATENCY - 1);

  // Control state (reset)
  state_e      state_q,        state_d;
  logic        busy_q,         busy_d;
  logic        done_q,         done_d;
  logic        error_q,        error_d;
  logic [7:0]  sum_q,          sum_d;
  logic [15:0] bram_address_q, bram_address_d;

  // Datapath state (no reset; always written before use)
  logic [15:0]       addr_q,     addr_d;
  logic [15:0]       end_addr_q, end_addr_d;
  logic [15:0]       len_q,      len_d;
  logic [7:0]        data_q,     data_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;

  // Issuer handshake
  logic       send_req;
  logic [7:0] send_byte;
  logic       byte_sent;

  tx_byte_issuer u_issuer (
    .clk        (clk),
    .rst        (rst),
    .send_req   (send_req),
    .send_byte  (send_byte),
    .tx_done    (tx_done),
    .tx_byte    (tx_byte),
    .tx_trigger (tx_trigger),
    .byte_sent  (byte_sent)
  );

  // Every byte is requested on the transition into its state, so the
  // issuer's registered tx_trigger lines up with the first cycle of that state.
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    sum_d          = sum_q;
    bram_address_d = bram_address_q;
    addr_d         = addr_q;
    end_addr_d     = end_addr_q;
    len_d          = len_q;
    data_d         = data_q;
    wait_d         = wait_q;
    send_req       = 1'b0;
    send_byte      = 8'h00;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_address <= end_address) begin
            addr_d     = start_address;
            end_addr_d = end_address;
            len_d      = end_address - start_address;
            sum_d      = 8'h00;
            busy_d     = 1'b1;
            send_req   = 1'b1;
            send_byte  = HEADER_BYTE;
            state_d    = HDR;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      HDR: begin
        if (byte_sent) begin
          send_req  = 1'b1;
          send_byte = len_q[15:8];
          state_d   = LEN_HI;
        end
      end

      LEN_HI: begin
        if (byte_sent) begin
          send_req  = 1'b1;
          send_byte = len_q[7:0];
          state_d   = LEN_LO;
        end
      end

      LEN_LO: begin
        if (byte_sent) begin
          bram_address_d = addr_q;
          state_d        = RD_REQ;
        end
      end

      // bram_address already holds addr_q here; start counting read latency.
      RD_REQ: begin
        wait_d  = '0;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          data_d    = bram_byte_read;
          send_req  = 1'b1;
          send_byte = bram_byte_read;
          state_d   = DATA;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // Compare against the end address before incrementing so that a range
      // ending at 16'hFFFF stops cleanly instead of wrapping to 16'h0000.
      DATA: begin
        if (byte_sent) begin
          sum_d = sum_q + data_q;
          if (addr_q == end_addr_q) begin
            send_req  = 1'b1;
            send_byte = sum_q + data_q;
            state_d   = SUM;
          end else begin
            addr_d         = addr_q + 16'd1;
            bram_address_d = addr_q + 16'd1;
            state_d        = RD_REQ;
          end
        end
      end

      SUM: begin
        if (byte_sent) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      sum_q          <= 8'h00;
      bram_address_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      sum_q          <= sum_d;
      bram_address_q <= bram_address_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    end_addr_q <= end_addr_d;
    len_q      <= len_d;
    data_q     <= data_d;
    wait_q     <= wait_d;
  end

  assign bram_address = bram_address_q;
  assign bram_mode    = 1'b0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_bram_uploader.sv
// ----------------------------------------------------------------------------
// tb_bram_uploader
//   Bench for bram_uploader: BRAM model, UART transmitter model with random
//   byte times and optional stray tx_done pulses, an output monitor, and a
//   frame-level reference model built directly from the frame definition.
// ----------------------------------------------------------------------------
module tb_bram_uploader;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] start_address;
  logic [15:0] end_address;
  logic [7:0]  bram_byte_read;
  logic [15:0] bram_address;
  logic        bram_mode;
  logic [7:0]  tx_byte;
  logic        tx_trigger;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  bram_uploader #(
    .HEADER_BYTE       (HDR),
    .BRAM_READ_LATENCY (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_address  (start_address),
    .end_address    (end_address),
    .bram_byte_read (bram_byte_read),
    .bram_address   (bram_address),
    .bram_mode      (bram_mode),
    .tx_byte        (tx_byte),
    .tx_trigger     (tx_trigger),
    .tx_done        (tx_done),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  // Synchronous one-cycle-latency BRAM
  logic [7:0] mem [65536];
  always @(posedge clk) bram_byte_read <= mem[bram_address];

  int vectors = 0;
  int miscompares = 0;

  // Transmitter model
  bit pending = 1'b0;
  int delay = 0;
  bit spur_en = 1'b0;
  int real_done_cnt = 0;
  int spur_cnt = 0;

  initial begin : xmit
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (pending) begin
        if (delay == 0) begin
          tx_done = 1'b1;
          pending = 1'b0;
          real_done_cnt++;
        end else begin
          delay--;
        end
      end else if (tx_trigger) begin
        pending = 1'b1;
        delay   = $urandom_range(0, 3);
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        tx_done = 1'b1;
        spur_cnt++;
      end
    end
  end

  // Output monitor
  byte_q_t    cap_q;
  int         trig_cnt = 0;
  int         done_pulses = 0;
  int         err_pulses = 0;
  int         busy_cycles = 0;
  int         zero_addr_cycles = 0;
  int         hold_viol = 0;
  bit         watch_zero = 1'b0;
  logic [7:0] last_byte = 8'h00;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done)  done_pulses++;
      if (error) err_pulses++;
      if (busy)  busy_cycles++;
      if (watch_zero && bram_address == 16'h0000) zero_addr_cycles++;
      if (rst) begin
        last_byte = 8'h00;
      end else if (tx_trigger) begin
        cap_q.push_back(tx_byte);
        trig_cnt++;
        last_byte = tx_byte;
      end else if (tx_byte !== last_byte) begin
        hold_viol++;
      end
    end
  end

  // Reference frame: header, 16-bit (end-start), data ascending, byte sum.
  function automatic byte_q_t ref_frame(input int s, input int e);
    byte_q_t q;
    int len;
    int sum;
    len = e - s;
    sum = 0;
    q.push_back(HDR);
    q.push_back(8'(len >> 8));
    q.push_back(8'(len));
    for (int a = s; a <= e; a++) begin
      q.push_back(mem[a]);
      sum += int'(mem[a]);
    end
    q.push_back(8'(sum % 256));
    return q;
  endfunction

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] e);
    @(negedge clk);
    start_address = s;
    end_address   = e;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, required 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b, required 0", error); end
    vectors++; if (tx_trigger !== 1'b0) begin miscompares++; $display("FAIL reset_trigger: got %b, required 0", tx_trigger); end
    vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte: got %h, required 00", tx_byte); end
    vectors++; if (bram_address !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h, required 0000", bram_address); end
    vectors++; if (bram_mode !== 1'b0) begin miscompares++; $display("FAIL reset_mode: got %b, required 0", bram_mode); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    byte_q_t exp_q;
    int b0, d0;
    bit to;
    mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h02; mem[16'h0012] = 8'h03;
    exp_q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h06};
    b0 = cap_q.size(); d0 = done_pulses;
    pulse_start(16'h0010, 16'h0012);
    vectors++; if (tx_trigger !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_latency: trigger=%b busy=%b, required 1 1", tx_trigger, busy); end
    wait_done(to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout: done not seen, required within 3000 cycles"); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b, required 0", busy); end
    repeat (4) @(negedge clk);
    vectors++; if (done_pulses - d0 != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d, required 1", done_pulses - d0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
    vectors++;
    if (cap_q.size() - b0 != exp_q.size()) begin
      miscompares++; $display("FAIL basic_length: got %0d bytes, required %0d", cap_q.size() - b0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_byte%0d: got %h, required %h", i, cap_q[b0 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_single();
    byte_q_t exp_q;
    int b0;
    bit to;
    mem[16'h0020] = 8'hFF;
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF};
    b0 = cap_q.size();
    pulse_start(16'h0020, 16'h0020);
    wait_done(to);
    vectors++; if (to) begin miscompares++; $display("FAIL single_timeout: done not seen, required within 3000 cycles"); end
    repeat (4) @(negedge clk);
    vectors++;
    if (cap_q.size() - b0 != exp_q.size()) begin
      miscompares++; $display("FAIL single_length: got %0d bytes, required %0d", cap_q.size() - b0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL single_byte%0d: got %h, required %h", i, cap_q[b0 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_range_error();
    int t0, e0, bc0;
    t0 = trig_cnt; e0 = err_pulses; bc0 = busy_cycles;
    pulse_start(16'h0030, 16'h002F);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_pulse: got %b, required 1", error); end
    @(negedge clk);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL error_width: got %b, required 0", error); end
    repeat (8) @(negedge clk);
    vectors++; if (trig_cnt != t0) begin miscompares++; $display("FAIL error_no_tx: got %0d triggers, required 0", trig_cnt - t0); end
    vectors++; if (busy_cycles != bc0) begin miscompares++; $display("FAIL error_busy: got %0d busy cycles, required 0", busy_cycles - bc0); end
    vectors++; if (err_pulses - e0 != 1) begin miscompares++; $display("FAIL error_count: got %0d pulses, required 1", err_pulses - e0); end
  endtask

  task automatic test_top_of_memory();
    byte_q_t exp_q;
    int b0, z0;
    bit to;
    mem[16'hFFFE] = 8'h80; mem[16'hFFFF] = 8'h80; mem[16'h0000] = 8'h5A;
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h80, 8'h80, 8'h00};
    b0 = cap_q.size(); z0 = zero_addr_cycles;
    pulse_start(16'hFFFE, 16'hFFFF);
    watch_zero = 1'b1;
    wait_done(to);
    repeat (5) @(negedge clk);
    watch_zero = 1'b0;
    vectors++; if (to) begin miscompares++; $display("FAIL top_timeout: done not seen, required within 3000 cycles"); end
    vectors++; if (zero_addr_cycles != z0) begin miscompares++; $display("FAIL top_no_wrap: address 0000 seen %0d cycles, required 0", zero_addr_cycles - z0); end
    vectors++;
    if (cap_q.size() - b0 != exp_q.size()) begin
      miscompares++; $display("FAIL top_length: got %0d bytes, required %0d", cap_q.size() - b0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL top_byte%0d: got %h, required %h", i, cap_q[b0 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t exp_q;
    int b0, t0, r0, d0, h0;
    int s, e;
    bit to;
    s = $urandom_range(16'h0100, 16'h0400);
    e = s + $urandom_range(3, 12);
    exp_q = ref_frame(s, e);
    b0 = cap_q.size(); t0 = trig_cnt; r0 = real_done_cnt; d0 = done_pulses; h0 = hold_viol;
    spur_en = 1'b1;
    pulse_start(16'(s), 16'(e));
    repeat (6) @(negedge clk);
    start_address = 16'(s + 100);
    end_address   = 16'(s + 120);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    spur_en = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: done not seen, required within 3000 cycles"); end
    vectors++; if (trig_cnt - t0 != real_done_cnt - r0) begin miscompares++; $display("FAIL b2b_trig_per_done: got %0d triggers, required %0d", trig_cnt - t0, real_done_cnt - r0); end
    vectors++; if (done_pulses - d0 != 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d, required 1", done_pulses - d0); end
    vectors++; if (hold_viol != h0) begin miscompares++; $display("FAIL b2b_hold: tx_byte changed %0d times between triggers, required 0", hold_viol - h0); end
    vectors++;
    if (cap_q.size() - b0 != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_length: got %0d bytes, required %0d", cap_q.size() - b0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_byte%0d: got %h, required %h", i, cap_q[b0 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t exp_q;
    int seen, n, t1, bc1, b0;
    bit to;
    for (int a = 16'h0010; a <= 16'h0012; a++) mem[a] = 8'($urandom);
    pulse_start(16'h0010, 16'h0012);
    seen = 1;  // header trigger is visible now
    n = 0;
    while (seen < 5 && n < 500) begin
      @(negedge clk);
      n++;
      if (tx_trigger) seen++;
    end
    vectors++; if (seen != 5) begin miscompares++; $display("FAIL rstmid_reach: got %0d triggers, required 5", seen); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || tx_trigger !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_ctrl: busy=%b done=%b error=%b trig=%b, required 0 0 0 0", busy, done, error, tx_trigger); end
    vectors++; if (tx_byte !== 8'h00 || bram_address !== 16'h0000)
      begin miscompares++; $display("FAIL rstmid_data: tx_byte=%h addr=%h, required 00 0000", tx_byte, bram_address); end
    @(negedge clk);
    rst = 1'b0;
    t1 = trig_cnt; bc1 = busy_cycles;
    repeat (10) @(negedge clk);
    vectors++; if (trig_cnt != t1) begin miscompares++; $display("FAIL rstmid_no_tx: got %0d triggers after reset, required 0", trig_cnt - t1); end
    vectors++; if (busy_cycles != bc1) begin miscompares++; $display("FAIL rstmid_idle: got %0d busy cycles, required 0", busy_cycles - bc1); end
    exp_q = ref_frame(16'h0010, 16'h0010);
    b0 = cap_q.size();
    pulse_start(16'h0010, 16'h0010);
    wait_done(to);
    repeat (4) @(negedge clk);
    vectors++; if (to) begin miscompares++; $display("FAIL rstmid_timeout: done not seen, required within 3000 cycles"); end
    vectors++;
    if (cap_q.size() - b0 != 5) begin
      miscompares++; $display("FAIL rstmid_length: got %0d bytes, required 5", cap_q.size() - b0);
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h, required %h", i, cap_q[b0 + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_frames();
    byte_q_t exp_q;
    int b0, e0, s, e;
    bit to;
    for (int k = 0; k < 6; k++) begin
      s = $urandom_range(0, 16'hFFE0);
      e = s + $urandom_range(0, 15);
      exp_q = ref_frame(s, e);
      b0 = cap_q.size(); e0 = err_pulses;
      pulse_start(16'(s), 16'(e));
      wait_done(to);
      repeat (3) @(negedge clk);
      vectors++; if (to || err_pulses != e0) begin miscompares++; $display("FAIL rand%0d_status: timeout=%b errors=%0d, required 0 0", k, to, err_pulses - e0); end
      vectors++;
      if (cap_q.size() - b0 != exp_q.size()) begin
        miscompares++; $display("FAIL rand%0d_length: got %0d bytes, required %0d", k, cap_q.size() - b0, exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          vectors++;
          if (cap_q[b0 + i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_byte%0d: got %h, required %h", k, i, cap_q[b0 + i], exp_q[i]); end
        end
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst           = 1'b1;
    start         = 1'b0;
    start_address = 16'h0000;
    end_address   = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_single();
    test_range_error();
    test_top_of_memory();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
